// File: rtl/ci_pkg.sv
// -----------------------------------------------------------------------------
// ci_pkg
// Shared types and constants for the CI histogram normaliser.
//   ci_state_e  : normaliser FSM states (IDLE, DIV, OUT)
//   BIN0 / BIN1 : bin index constants
//   ROUND_BITS  : extra quotient bits computed for rounding
//   DIV_ITERS   : divider iterations for the default 16-bit fraction
//   div_iters() : divider iterations for an arbitrary fraction width
// Configuration macro: CI_NORM_ROUND_EN (defined = round-half-up result,
// undefined = truncated result).
// -----------------------------------------------------------------------------
package ci_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        OUT  = 2'd2
    } ci_state_e;

    localparam logic BIN0 = 1'b0;
    localparam logic BIN1 = 1'b1;

`ifdef CI_NORM_ROUND_EN
    localparam int ROUND_BITS = 1;
`else
    localparam int ROUND_BITS = 0;
`endif

    localparam int FRAC_W_DEF = 16;
    localparam int DIV_ITERS  = FRAC_W_DEF + 1 + ROUND_BITS;

    // Quotient bits needed: integer bit (ratio can be exactly 1.0), the
    // fraction bits, plus one guard bit when rounding.
    function automatic int div_iters(input int frac_w);
        return frac_w + 1 + ROUND_BITS;
    endfunction

endpackage

// File: rtl/ci_serial_div.sv
// -----------------------------------------------------------------------------
// ci_serial_div
// Serial restoring divider, one quotient bit per clock.
// Computes floor(i_dividend * 2^(Q_W-1) / i_divisor) for
// i_dividend <= i_divisor and i_divisor != 0, so the quotient fits Q_W bits.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture operands and start (restarts a running division)
//   i_dividend     : numerator, NUM_W bits (NUM_W <= DEN_W)
//   i_divisor      : denominator, DEN_W bits
//   o_done         : high during the cycle whose clock edge forms the last bit
//   o_quotient     : quotient including the bit formed this cycle; complete
//                    and valid while o_done is high
// -----------------------------------------------------------------------------
module ci_serial_div #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 25,
    parameter int Q_W   = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [NUM_W-1:0] i_dividend,
    input  logic [DEN_W-1:0] i_divisor,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quotient
);

    localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    logic             run_q;
    logic [CNT_W-1:0] iter_q;
    // Partial remainder stays below 2*divisor, hence one bit wider than it.
    logic [DEN_W:0]   rem_q;
    logic [DEN_W-1:0] den_q;
    logic [Q_W-1:0]   quo_q;

    logic             fits;
    logic [DEN_W:0]   rem_sub;
    logic [DEN_W:0]   rem_nxt;
    logic [Q_W-1:0]   quo_nxt;
    logic             last_iter;

    // Compare-then-shift: the first step yields the integer bit (weight
    // 2^(Q_W-1)) without pre-shifting the numerator.
    always_comb begin
        fits      = (rem_q >= {1'b0, den_q});
        rem_sub   = rem_q - {1'b0, den_q};
        rem_nxt   = fits ? (rem_sub << 1) : (rem_q << 1);
        quo_nxt   = {quo_q[Q_W-2:0], fits};
        last_iter = (iter_q == CNT_W'(Q_W - 1));
    end

    assign o_done     = run_q & last_iter;
    assign o_quotient = quo_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q  <= 1'b0;
            iter_q <= '0;
        end else if (i_load) begin
            run_q  <= 1'b1;
            iter_q <= '0;
        end else if (run_q) begin
            iter_q <= iter_q + CNT_W'(1);
            if (last_iter) begin
                run_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            rem_q <= (DEN_W+1)'(i_dividend);
            den_q <= i_divisor;
            quo_q <= '0;
        end else if (run_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/ci_hist_norm.sv
// -----------------------------------------------------------------------------
// ci_hist_norm
// Normalises the two CI histogram bin counts to fixed-point fractions of
// their total (2^FRAC_W == 1.0) and streams them out as two words.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_start            : one-cycle "frame done" pulse, counts stable
//   i_cnt_0, i_cnt_1   : bin counts, WIDTH_DATA bits
//   o_busy             : high from capture until the bin 1 handshake
//   o_valid / i_ready  : output word handshake
//   o_data             : normalised value, FRAC_W+1 bits
//   o_bin              : bin index of o_data
//   o_last             : marks the bin 1 word
// Configuration macro: CI_NORM_ROUND_EN rounds half-up instead of truncating
// (one extra divider iteration).
// -----------------------------------------------------------------------------
module ci_hist_norm
    import ci_pkg::*;
#(
    parameter int WIDTH_DATA = 24,
    parameter int FRAC_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [WIDTH_DATA-1:0] i_cnt_0,
    input  logic [WIDTH_DATA-1:0] i_cnt_1,
    output logic                  o_busy,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [FRAC_W:0]       o_data,
    output logic                  o_bin,
    output logic                  o_last
);

    localparam int ITERS = div_iters(FRAC_W);
    localparam int TOT_W = WIDTH_DATA + 1;

    ci_state_e             state_q;
    logic                  bin_q;
    logic [WIDTH_DATA-1:0] cnt1_q;
    logic [TOT_W-1:0]      total_q;

    logic [TOT_W-1:0]      total_in;
    logic                  div_load;
    logic [WIDTH_DATA-1:0] div_dividend;
    logic [TOT_W-1:0]      div_divisor;
    logic                  div_done;
    logic [ITERS-1:0]      div_quot;

    // Raw quotient to output word. With rounding the guard bit is added back;
    // the result cannot exceed 2^FRAC_W because an exact 1.0 leaves a zero
    // guard bit.
    function automatic logic [FRAC_W:0] norm_word(input logic [ITERS-1:0] q);
`ifdef CI_NORM_ROUND_EN
        return q[FRAC_W+1:1] + (FRAC_W+1)'(q[0]);
`else
        return q;
`endif
    endfunction

    assign total_in = {1'b0, i_cnt_0} + {1'b0, i_cnt_1};
    assign o_busy   = (state_q != IDLE);

    // Bin 0 divides straight from the inputs on the capture edge; bin 1
    // is loaded on the bin 0 handshake edge from the latched values.
    always_comb begin
        div_load     = 1'b0;
        div_dividend = cnt1_q;
        div_divisor  = total_q;
        if (state_q == IDLE) begin
            div_dividend = i_cnt_0;
            div_divisor  = total_in;
            div_load     = i_start && (total_in != '0);
        end else if (state_q == OUT) begin
            div_load = i_ready && (bin_q == BIN0) && (total_q != '0);
        end
    end

    ci_serial_div #(
        .NUM_W (WIDTH_DATA),
        .DEN_W (TOT_W),
        .Q_W   (ITERS)
    ) u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (div_load),
        .i_dividend (div_dividend),
        .i_divisor  (div_divisor),
        .o_done     (div_done),
        .o_quotient (div_quot)
    );

    // Capture registers: only written from IDLE, so a start pulse while busy
    // cannot disturb an ongoing frame.
    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && i_start) begin
            cnt1_q  <= i_cnt_1;
            total_q <= total_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bin_q   <= BIN0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_bin   <= BIN0;
            o_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        bin_q <= BIN0;
                        if (total_in == '0) begin
                            state_q <= OUT;
                            o_valid <= 1'b1;
                            o_data  <= '0;
                            o_bin   <= BIN0;
                            o_last  <= 1'b0;
                        end else begin
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state_q <= OUT;
                        o_valid <= 1'b1;
                        o_data  <= norm_word(div_quot);
                        o_bin   <= bin_q;
                        o_last  <= (bin_q == BIN1);
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (bin_q == BIN0) begin
                            bin_q <= BIN1;
                            if (total_q == '0) begin
                                // Empty frame: bin 1 word follows immediately.
                                o_valid <= 1'b1;
                                o_data  <= '0;
                                o_bin   <= BIN1;
                                o_last  <= 1'b1;
                            end else begin
                                state_q <= DIV;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ci_hist_norm.sv
module tb_ci_hist_norm;

    localparam int WD     = 24;
    localparam int FRAC_W = 16;
`ifdef CI_NORM_ROUND_EN
    localparam int ITERS = FRAC_W + 2;
`else
    localparam int ITERS = FRAC_W + 1;
`endif
    localparam int LAT_DIV = ITERS + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_start = 1'b0;
    logic [WD-1:0]   i_cnt_0 = '0;
    logic [WD-1:0]   i_cnt_1 = '0;
    logic            i_ready = 1'b1;
    logic            o_busy;
    logic            o_valid;
    logic [FRAC_W:0] o_data;
    logic            o_bin;
    logic            o_last;

    int n_cmp = 0;
    int n_bad = 0;

    ci_hist_norm #(.WIDTH_DATA(WD), .FRAC_W(FRAC_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .i_cnt_0 (i_cnt_0),
        .i_cnt_1 (i_cnt_1),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_bin   (o_bin),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected normalised value from plain rational arithmetic.
    function automatic longint exp_word(input longint c, input longint t);
        if (t == 0) return 0;
`ifdef CI_NORM_ROUND_EN
        return ((c << (FRAC_W + 1)) + t) / (2 * t);
`else
        return (c << FRAC_W) / t;
`endif
    endfunction

    // ---------------- reference model + per-cycle compare -------------------
    typedef struct {
        longint data;
        bit     bin;
        bit     last;
    } word_t;

    word_t  m_q[$];
    int     cyc = 0;
    int     m_start = 0;
    int     m_lat = 1;
    bit     m_vld;
    longint m_tot;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", o_valid, 0);
            check("rst_busy", o_busy, 0);
            check("rst_data", o_data, 0);
            check("rst_bin", o_bin, 0);
            check("rst_last", o_last, 0);
            m_q.delete();
        end else begin
            m_vld = (m_q.size() != 0) && ((cyc - m_start) >= (m_lat - 1));
            check("busy", o_busy, longint'(m_q.size() != 0));
            check("valid", o_valid, longint'(m_vld));
            if (m_vld) begin
                check("data", o_data, m_q[0].data);
                check("bin", o_bin, longint'(m_q[0].bin));
                check("last", o_last, longint'(m_q[0].last));
            end
            if (m_q.size() == 0) begin
                if (i_start) begin
                    m_tot = longint'(i_cnt_0) + longint'(i_cnt_1);
                    m_q.push_back('{exp_word(longint'(i_cnt_0), m_tot), 1'b0, 1'b0});
                    m_q.push_back('{exp_word(longint'(i_cnt_1), m_tot), 1'b1, 1'b1});
                    m_lat   = (m_tot == 0) ? 1 : LAT_DIV;
                    m_start = cyc + 1;
                end
            end else if (m_vld && i_ready) begin
                void'(m_q.pop_front());
                m_start = cyc + 1;
            end
        end
        cyc++;
    end

    // ---------------- directed helpers --------------------------------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (o_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (o_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: o_busy still 1, expected 0");
        end
    endtask

    task automatic get_word(input bit b, output int n);
        n = 0;
        @(negedge clk);
        while (!(o_valid && o_bin == b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(o_valid && o_bin == b)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL word_timeout: bin %0d word never valid", b);
        end
    endtask

    task automatic pulse_start(input logic [WD-1:0] c0, input logic [WD-1:0] c1);
        @(posedge clk);
        #2;
        i_cnt_0 = c0;
        i_cnt_1 = c1;
        i_start = 1'b1;
        @(posedge clk);
        #2;
        i_start = 1'b0;
    endtask

    task automatic frame(input string nm, input logic [WD-1:0] c0, input logic [WD-1:0] c1,
                         input longint e0, input longint e1, input int elat, input bit hold);
        int n;
        wait_idle();
        i_ready = !hold;
        pulse_start(c0, c1);
        get_word(1'b0, n);
        check({nm, "_lat"}, n + 1, elat);
        check({nm, "_w0"}, o_data, e0);
        check({nm, "_last0"}, o_last, 0);
        if (hold) begin
            repeat (10) @(posedge clk);
            #2 i_ready = 1'b1;
            @(posedge clk);
            #2 i_ready = 1'b0;
        end
        get_word(1'b1, n);
        check({nm, "_w1"}, o_data, e1);
        check({nm, "_last1"}, o_last, 1);
        if (hold) begin
            repeat (10) @(posedge clk);
            #2 i_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({nm, "_busy_end"}, o_busy, 0);
        i_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        int n;
        // Pin the model to hand-computed values.
        check("pin_75_100", exp_word(75, 100), 49152);
        check("pin_25_100", exp_word(25, 100), 16384);
        check("pin_100_100", exp_word(100, 100), 65536);
`ifdef CI_NORM_ROUND_EN
        check("pin_2_3", exp_word(2, 3), 43691);
`else
        check("pin_2_3", exp_word(2, 3), 43690);
`endif

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        frame("r75_25", 24'd75, 24'd25, 49152, 16384, LAT_DIV, 1'b0);
        frame("zero", 24'd0, 24'd0, 0, 0, 1, 1'b0);
`ifdef CI_NORM_ROUND_EN
        frame("r1_2", 24'd1, 24'd2, 21845, 43691, LAT_DIV, 1'b0);
`else
        frame("r1_2", 24'd1, 24'd2, 21845, 43690, LAT_DIV, 1'b0);
`endif
        frame("hold0_100", 24'd0, 24'd100, 0, 65536, LAT_DIV, 1'b1);
        frame("full", 24'hFFFFFF, 24'hFFFFFF, 32768, 32768, LAT_DIV, 1'b0);

        // Second start mid-division is ignored.
        wait_idle();
        pulse_start(24'd10, 24'd30);
        repeat (4) @(posedge clk);
        pulse_start(24'd7, 24'd9);
        get_word(1'b0, n);
        check("restart_w0", o_data, 16384);
        get_word(1'b1, n);
        check("restart_w1", o_data, 49152);
        @(posedge clk);
        @(negedge clk);
        check("restart_busy_end", o_busy, 0);

        // Reset during bin 1 division.
        pulse_start(24'd50, 24'd50);
        get_word(1'b0, n);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_busy", o_busy, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        frame("after_rst", 24'd3, 24'd1, 49152, 16384, LAT_DIV, 1'b0);

        // Randomised traffic: random counts, back-pressure and stray starts.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            i_ready = ($urandom_range(0, 3) != 0);
            i_start = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: begin
                    i_cnt_0 = WD'($urandom_range(0, 3));
                    i_cnt_1 = WD'($urandom_range(0, 3));
                end
                1: begin
                    i_cnt_0 = WD'($urandom);
                    i_cnt_1 = WD'($urandom);
                end
                2: begin
                    i_cnt_0 = '0;
                    i_cnt_1 = WD'($urandom);
                end
                default: begin
                    i_cnt_0 = WD'($urandom);
                    i_cnt_1 = i_cnt_0;
                end
            endcase
        end
        @(posedge clk);
        #2;
        i_start = 1'b0;
        i_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
